mbtrain_sb_responder: RTL and testbench
=======================================

MBTRAIN_SB_RESPONDER -- requirements
Module: mbtrain_sb_responder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 800000, cycles of clk_100MHz without progress before timeout (8 ms).
REQ-002 Parameter NUM_SUBSTATES, default 12, number of MBTRAIN substates walked (VALVREF..LINKSPEED, REPAIR excluded).
REQ-003 clk_100MHz input 1: the block's one clock; every flop is clocked on its rising edge.
REQ-004 reset input 1: synchronous, active-high.
REQ-005 enable_i input 1: LTSM is in MBTRAIN; low forces IDLE.
REQ-006 RX_msg_i input SB_msg_t: sideband message received from the partner.
REQ-007 RX_msg_valid_i input 1: RX_msg_i is valid.
REQ-008 RX_msg_req_o output 1: responder ready to consume an RX message.
REQ-009 TX_msg_o output SB_msg_t: response message to the partner.
REQ-010 TX_msg_valid_o output 1: TX_msg_o is valid.
REQ-011 TX_msg_valid_ack_i input 1: sideband TX accepted TX_msg_o.
REQ-012 substate_o output 4: index of the current substate, 0..NUM_SUBSTATES-1.
REQ-013 MBTRAIN_resp_done_o output 1: all substates completed.
REQ-014 timeout_o output 1: no progress for TIMEOUT_CYCLES.
REQ-015 reset_state_timeout_counter_o output 1: one-cycle pulse on each completed response.

Function
REQ-016 States: IDLE, WAIT_START_REQ, SEND_START_RESP, WAIT_END_REQ, SEND_END_RESP, DONE, TIMEOUT.
REQ-017 IDLE -> WAIT_START_REQ on the first cycle enable_i=1, with the substate index cleared to 0.
REQ-018 RX_msg_req_o=1 only in the WAIT_* states; a message is consumed on a cycle where RX_msg_valid_i=1 and RX_msg_req_o=1.
REQ-019 In WAIT_START_REQ, a consumed message equal to the start-request encoding (SB_codex_pkg) of the current substate moves the FSM to SEND_START_RESP on the next cycle.
REQ-020 In WAIT_END_REQ, a consumed message equal to the end request of the current substate moves the FSM to SEND_END_RESP.
REQ-021 A consumed message that does not match is dropped: no state change and no timer reset.
REQ-022 In SEND_* states, TX_msg_valid_o=1 with TX_msg_o = matching response encoding, both held stable until TX_msg_valid_ack_i=1.
REQ-023 An ack and a new RX message can never be taken in the same cycle, because RX_msg_req_o=0 in SEND_* states.
REQ-024 Ack in SEND_START_RESP: go to WAIT_END_REQ.
REQ-025 Ack in SEND_END_RESP: if index = NUM_SUBSTATES-1 go to DONE, else increment the index and go to WAIT_START_REQ.
REQ-026 Each ack pulses reset_state_timeout_counter_o for exactly one cycle, in the cycle after the ack.
REQ-027 TX_msg_valid_o drops in the cycle after the ack; response-to-next-request latency is 1 cycle minimum.
REQ-028 DONE: MBTRAIN_resp_done_o=1 (level), held until enable_i=0.
REQ-029 Timer: counter of width $clog2(TIMEOUT_CYCLES+1), cleared on IDLE entry and on each ack, incremented every cycle in WAIT_*/SEND_* states.
REQ-030 When the timer reaches TIMEOUT_CYCLES the FSM goes to TIMEOUT: timeout_o=1, all valid/req outputs 0, held until enable_i=0.
REQ-031 Timeout takes priority over a same-cycle ack or message.
REQ-032 enable_i=0 in any state: next cycle IDLE, outputs at reset values; any in-flight TX message is abandoned.
REQ-033 The index saturates at NUM_SUBSTATES-1 and never wraps.

Reset
REQ-034 On reset: state IDLE, index 0, timer 0.
REQ-035 Reset values: RX_msg_req_o, TX_msg_valid_o, MBTRAIN_resp_done_o, timeout_o and reset_state_timeout_counter_o all 0; TX_msg_o all-zero; substate_o 0.
REQ-036 Reset has priority over enable_i.

Structure
REQ-037 The MBTRAIN request/response encodings and an enum of substate indices belong in SB_codex_pkg.
REQ-038 The FSM state enum is local to the module.
REQ-039 One sub-module, mbtrain_msg_lut (combinational): substate index -> {start_req, start_resp, end_req, end_resp}.

Verification
REQ-040 Full walk: 12 start/end request pairs with ack 1 cycle after valid -> 24 responses in order, 24 counter-reset pulses, done=1, substate_o=11.
REQ-041 Ack delayed 5 cycles -> TX_msg_o/valid stable for 6 cycles, RX_msg_req_o=0 throughout.
REQ-042 At substate 3, wrong message, then the correct start request -> the first is dropped and the response follows the second; substate_o stays 3.
REQ-043 TIMEOUT_CYCLES=100, no request after entry -> timeout_o=1 exactly 100 cycles after leaving IDLE.
REQ-044 enable_i=0 while TX_msg_valid_o=1 at substate 5 -> IDLE next cycle; re-enable restarts at index 0.
REQ-045 reset asserted mid-walk -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/SB_codex_pkg.sv
// rtl/SB_codex_pkg.sv - sideband message type, MBTRAIN substate indices and request/response encodings
package SB_codex_pkg;

  typedef struct packed {
    logic [7:0] msg_code;
    logic [7:0] msg_info;
  } SB_msg_t;

  typedef enum logic [3:0] {
    SS_VALVREF          = 4'd0,
    SS_DATAVREF         = 4'd1,
    SS_SPEEDIDLE        = 4'd2,
    SS_TXSELFCAL        = 4'd3,
    SS_RXCLKCAL         = 4'd4,
    SS_VALTRAINCENTER   = 4'd5,
    SS_VALTRAINVREF     = 4'd6,
    SS_DATATRAINCENTER1 = 4'd7,
    SS_DATATRAINVREF    = 4'd8,
    SS_RXDESKEW         = 4'd9,
    SS_DATATRAINCENTER2 = 4'd10,
    SS_LINKSPEED        = 4'd11
  } mbtrain_substate_e;

  localparam logic [7:0] MBTRAIN_REQ_CODE  = 8'hB5;
  localparam logic [7:0] MBTRAIN_RESP_CODE = 8'hBA;

  // msg_info carries the substate index in the upper nibble and start(0)/end(1) in bit 0
  function automatic SB_msg_t mbtrain_msg(input logic is_resp, input mbtrain_substate_e ss,
                                          input logic is_end);
    SB_msg_t m;
    m.msg_code = is_resp ? MBTRAIN_RESP_CODE : MBTRAIN_REQ_CODE;
    m.msg_info = {ss, 3'b000, is_end};
    return m;
  endfunction

endpackage

// File: rtl/mbtrain_msg_lut.sv
// rtl/mbtrain_msg_lut.sv - substate index to start/end request and response encodings
module mbtrain_msg_lut
  import SB_codex_pkg::*;
(
  input  logic [3:0] idx_i,
  output SB_msg_t    start_req_o,
  output SB_msg_t    start_resp_o,
  output SB_msg_t    end_req_o,
  output SB_msg_t    end_resp_o
);

  mbtrain_substate_e ss;

  always_comb begin
    ss           = mbtrain_substate_e'(idx_i);
    start_req_o  = mbtrain_msg(1'b0, ss, 1'b0);
    start_resp_o = mbtrain_msg(1'b1, ss, 1'b0);
    end_req_o    = mbtrain_msg(1'b0, ss, 1'b1);
    end_resp_o   = mbtrain_msg(1'b1, ss, 1'b1);
  end

endmodule

// File: rtl/mbtrain_sb_responder.sv
// rtl/mbtrain_sb_responder.sv - MBTRAIN sideband responder: answers start/end requests for each substate
module mbtrain_sb_responder
  import SB_codex_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int NUM_SUBSTATES  = 12
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       enable_i,
  input  SB_msg_t    RX_msg_i,
  input  logic       RX_msg_valid_i,
  output logic       RX_msg_req_o,
  output SB_msg_t    TX_msg_o,
  output logic       TX_msg_valid_o,
  input  logic       TX_msg_valid_ack_i,
  output logic [3:0] substate_o,
  output logic       MBTRAIN_resp_done_o,
  output logic       timeout_o,
  output logic       reset_state_timeout_counter_o
);

  localparam int              TW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0]      LAST_IDX    = 4'(NUM_SUBSTATES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START_REQ,
    ST_SEND_START_RESP,
    ST_WAIT_END_REQ,
    ST_SEND_END_RESP,
    ST_DONE,
    ST_TIMEOUT
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pulse_q, pulse_d;
  logic [TW-1:0]   timer_inc;
  logic            rx_take;
  logic            active;
  SB_msg_t         start_req, start_resp, end_req, end_resp;

  mbtrain_msg_lut u_lut (
    .idx_i       (idx_q),
    .start_req_o (start_req),
    .start_resp_o(start_resp),
    .end_req_o   (end_req),
    .end_resp_o  (end_resp)
  );

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    RX_msg_req_o                  = (state_q == ST_WAIT_START_REQ) || (state_q == ST_WAIT_END_REQ);
    TX_msg_valid_o                = (state_q == ST_SEND_START_RESP) || (state_q == ST_SEND_END_RESP);
    TX_msg_o                      = '0;
    if (state_q == ST_SEND_START_RESP) TX_msg_o = start_resp;
    if (state_q == ST_SEND_END_RESP)   TX_msg_o = end_resp;
    MBTRAIN_resp_done_o           = (state_q == ST_DONE);
    timeout_o                     = (state_q == ST_TIMEOUT);
    substate_o                    = idx_q;
    reset_state_timeout_counter_o = pulse_q;

    rx_take   = RX_msg_valid_i && RX_msg_req_o;
    active    = RX_msg_req_o || TX_msg_valid_o;
    timer_inc = timer_q + TW'(1);

    state_d = state_q;
    idx_d   = idx_q;
    timer_d = active ? timer_inc : timer_q;
    pulse_d = 1'b0;

    if (!enable_i) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      timer_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT_START_REQ;
          idx_d   = '0;
          timer_d = '0;
        end
        ST_WAIT_START_REQ: if (rx_take && RX_msg_i == start_req) state_d = ST_SEND_START_RESP;
        ST_WAIT_END_REQ:   if (rx_take && RX_msg_i == end_req)   state_d = ST_SEND_END_RESP;
        ST_SEND_START_RESP: if (TX_msg_valid_ack_i) begin
          state_d = ST_WAIT_END_REQ;
          timer_d = '0;
          pulse_d = 1'b1;
        end
        ST_SEND_END_RESP: if (TX_msg_valid_ack_i) begin
          timer_d = '0;
          pulse_d = 1'b1;
          if (idx_q >= LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_START_REQ;
            idx_d   = idx_q + 4'd1;
          end
        end
        default: ;
      endcase

      // Running out of time wins over any ack or message seen in the same cycle
      if (active && timer_inc == TIMEOUT_VAL) begin
        state_d = ST_TIMEOUT;
        idx_d   = idx_q;
        timer_d = timer_inc;
        pulse_d = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mbtrain_sb_responder.sv
// tb/tb_mbtrain_sb_responder.sv - scoreboard bench for mbtrain_sb_responder
module tb_mbtrain_sb_responder;
  import SB_codex_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable_i = 1'b0;
  SB_msg_t    RX_msg_i = '0;
  logic       RX_msg_valid_i = 1'b0;
  logic       RX_msg_req_o;
  SB_msg_t    TX_msg_o;
  logic       TX_msg_valid_o;
  logic       TX_msg_valid_ack_i = 1'b0;
  logic [3:0] substate_o;
  logic       done_o, timeout_o, pulse_o;

  int n_checks = 0;
  int n_fail   = 0;
  int resp_cnt = 0;
  int pulse_cnt = 0;
  SB_msg_t exp_q[$];

  always #5 clk = ~clk;

  mbtrain_sb_responder #(.TIMEOUT_CYCLES(100), .NUM_SUBSTATES(12)) dut (
    .clk_100MHz                   (clk),
    .reset                        (reset),
    .enable_i                     (enable_i),
    .RX_msg_i                     (RX_msg_i),
    .RX_msg_valid_i               (RX_msg_valid_i),
    .RX_msg_req_o                 (RX_msg_req_o),
    .TX_msg_o                     (TX_msg_o),
    .TX_msg_valid_o               (TX_msg_valid_o),
    .TX_msg_valid_ack_i           (TX_msg_valid_ack_i),
    .substate_o                   (substate_o),
    .MBTRAIN_resp_done_o          (done_o),
    .timeout_o                    (timeout_o),
    .reset_state_timeout_counter_o(pulse_o)
  );

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding: code B5 request / BA response; info = {index, 3'b0, end}
  function automatic SB_msg_t exp_msg(input bit resp, input int idx, input bit is_end);
    SB_msg_t m;
    m.msg_code = resp ? 8'hBA : 8'hB5;
    m.msg_info = {idx[3:0], 3'b000, is_end};
    return m;
  endfunction

  // Monitor: compares presented responses to the queue, pops on handshake, checks the pulse
  initial begin
    bit hs_prev = 1'b0;
    bit hs_now;
    forever begin
      @(negedge clk);
      #2;
      chk(pulse_o == hs_prev, "ctr_reset_pulse", int'(pulse_o), int'(hs_prev));
      if (pulse_o) pulse_cnt++;
      hs_now = 1'b0;
      if (TX_msg_valid_o) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_tx", int'(TX_msg_o), 0);
        end else begin
          chk(TX_msg_o == exp_q[0], "tx_msg", int'(TX_msg_o), int'(exp_q[0]));
          if (TX_msg_valid_ack_i) begin
            void'(exp_q.pop_front());
            hs_now = 1'b1;
            resp_cnt++;
          end
        end
      end
      hs_prev = hs_now;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_req(input SB_msg_t m);
    RX_msg_i = m;
    RX_msg_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (RX_msg_req_o) begin
        @(negedge clk);
        RX_msg_valid_i = 1'b0;
        RX_msg_i = '0;
        return;
      end
      @(negedge clk);
    end
    RX_msg_valid_i = 1'b0;
    chk(1'b0, "rx_req_wait_expired", 0, 1);
  endtask

  task automatic ack_resp(input int d);
    int n = 0;
    while (!TX_msg_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(TX_msg_valid_o == 1'b1, "tx_valid_seen", int'(TX_msg_valid_o), 1);
    for (int i = 0; i < d; i++) begin
      chk(RX_msg_req_o == 1'b0, "rx_req_low_in_send", int'(RX_msg_req_o), 0);
      chk(TX_msg_valid_o == 1'b1, "tx_valid_held", int'(TX_msg_valid_o), 1);
      @(negedge clk);
    end
    TX_msg_valid_ack_i = 1'b1;
    @(negedge clk);
    TX_msg_valid_ack_i = 1'b0;
    chk(TX_msg_valid_o == 1'b0, "tx_valid_drop", int'(TX_msg_valid_o), 0);
  endtask

  task automatic send_wrong(input SB_msg_t target, input int idx);
    SB_msg_t w;
    w = SB_msg_t'(16'($urandom));
    if (w == target) w.msg_info = w.msg_info ^ 8'h01;
    send_req(w);
    chk(RX_msg_req_o == 1'b1, "wrong_msg_dropped", int'(RX_msg_req_o), 1);
    chk(int'(substate_o) == idx, "substate_after_drop", int'(substate_o), idx);
  endtask

  task automatic walk_substate(input int idx, input int d_start, input int d_end, input bit wrong);
    if (wrong) send_wrong(exp_msg(0, idx, 0), idx);
    exp_q.push_back(exp_msg(1, idx, 0));
    send_req(exp_msg(0, idx, 0));
    ack_resp(d_start);
    chk(int'(substate_o) == idx, "substate_mid", int'(substate_o), idx);
    if ($urandom_range(0, 3) == 0) send_wrong(exp_msg(0, idx, 1), idx);
    exp_q.push_back(exp_msg(1, idx, 1));
    send_req(exp_msg(0, idx, 1));
    ack_resp(d_end);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk(RX_msg_req_o == 1'b0, {tag, "_rx_req"}, int'(RX_msg_req_o), 0);
    chk(TX_msg_valid_o == 1'b0, {tag, "_tx_valid"}, int'(TX_msg_valid_o), 0);
    chk(TX_msg_o == '0, {tag, "_tx_msg"}, int'(TX_msg_o), 0);
    chk(substate_o == 4'd0, {tag, "_substate"}, int'(substate_o), 0);
    chk(done_o == 1'b0, {tag, "_done"}, int'(done_o), 0);
    chk(timeout_o == 1'b0, {tag, "_timeout"}, int'(timeout_o), 0);
    chk(pulse_o == 1'b0, {tag, "_pulse"}, int'(pulse_o), 0);
  endtask

  initial begin
    int leave, tmo;
    // Reset has priority over enable
    enable_i = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    chk(RX_msg_req_o == 1'b1, "enter_wait_start", int'(RX_msg_req_o), 1);

    // Full walk with random ack delays and stray messages
    resp_cnt = 0;
    pulse_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      walk_substate(i, (i == 7) ? 5 : int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    (i == 3) || ($urandom_range(0, 3) == 0));
    end
    @(negedge clk);
    chk(done_o == 1'b1, "walk_done", int'(done_o), 1);
    chk(substate_o == 4'd11, "walk_last_substate", int'(substate_o), 11);
    chk(resp_cnt == 24, "walk_resp_count", resp_cnt, 24);
    chk(pulse_cnt == 24, "walk_pulse_count", pulse_cnt, 24);
    repeat (4) @(negedge clk);
    chk(done_o == 1'b1, "done_held", int'(done_o), 1);
    chk(RX_msg_req_o == 1'b0, "done_no_rx_req", int'(RX_msg_req_o), 0);

    enable_i = 1'b0;
    @(negedge clk);
    check_idle_outputs("disable_done");

    // Abandon an in-flight response at substate 5
    enable_i = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) walk_substate(i, int'($urandom_range(0, 3)), 0, 1'b0);
    exp_q.push_back(exp_msg(1, 5, 0));
    send_req(exp_msg(0, 5, 0));
    chk(TX_msg_valid_o == 1'b1, "sub5_tx_valid", int'(TX_msg_valid_o), 1);
    chk(substate_o == 4'd5, "sub5_index", int'(substate_o), 5);
    enable_i = 1'b0;
    @(negedge clk);
    exp_q.delete();
    check_idle_outputs("abandon");
    enable_i = 1'b1;
    @(negedge clk);
    chk(RX_msg_req_o == 1'b1, "reenable_wait", int'(RX_msg_req_o), 1);
    chk(substate_o == 4'd0, "reenable_index", int'(substate_o), 0);
    walk_substate(0, 1, 0, 1'b0);
    walk_substate(1, 0, 1, 1'b1);

    // Reset in the middle of substate 2
    exp_q.push_back(exp_msg(1, 2, 0));
    send_req(exp_msg(0, 2, 0));
    ack_resp(0);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    @(negedge clk);

    // No request after leaving IDLE: timeout 100 cycles later
    reset = 1'b0;
    leave = -1;
    tmo = -1;
    for (int n = 1; n <= 200 && tmo < 0; n++) begin
      @(negedge clk);
      if (leave < 0 && RX_msg_req_o) leave = n;
      if (timeout_o) tmo = n;
    end
    chk(leave == 1, "leave_idle_cycle", leave, 1);
    chk(tmo >= 0 && (tmo - leave) == 100, "timeout_latency", tmo - leave, 100);
    RX_msg_i = exp_msg(0, 0, 0);
    RX_msg_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    RX_msg_valid_i = 1'b0;
    chk(timeout_o == 1'b1, "timeout_held", int'(timeout_o), 1);
    chk(RX_msg_req_o == 1'b0, "timeout_rx_req", int'(RX_msg_req_o), 0);
    chk(TX_msg_valid_o == 1'b0, "timeout_tx_valid", int'(TX_msg_valid_o), 0);
    enable_i = 1'b0;
    @(negedge clk);
    check_idle_outputs("timeout_clear");
    chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
